move_ascii_tx: RTL and testbench
================================

Name: move_ascii_tx

Overview:
Converts a binary TRAX move word into its ASCII notation and streams it byte-by-byte to the UART byte transmitter. Output string is column letters, row digits, tile char, then LF; for example column 27, row 128, tile '+' produces "AA128+\n".
Sits between game/move-selection logic and the UART TX byte interface. It is the outbound counterpart of the tranceiver's ASCII-to-move parser.

Parameters:
COL_W, 10, column field width; legal column range 0..702
ROW_W, 10, row field width; range 0..1023
CONV_CYCLES, 27, fixed conversion length in cycles; must be >= ROW_W and >= 27

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
move  in  22  [21:20] tile (00 '+', 01 '/', 10 '\', 11 illegal); [19:10] column; [9:0] row
byte_data  out  8  ASCII byte to the UART
byte_valid  out  1  byte_data is valid
byte_ready  in  1  UART accepts the byte this cycle
busy  out  1  high from start acceptance until the done or error pulse
done  out  1  1-cycle pulse after LF is accepted
error  out  1  1-cycle pulse when the move is rejected

Behaviour:
- Reset: state IDLE; byte_data=0, byte_valid=0, busy=0, done=0, error=0; all latched fields cleared. Reset mid-string aborts immediately and sends no further bytes.
- IDLE, start=1: latch move, busy=1 next cycle, go to CHECK. A start while busy is ignored.
- CHECK (1 cycle):
  - tile==11 or column>702: pulse error, busy=0, return to IDLE; no bytes sent.
  - Otherwise go to CONV.
- CONV (exactly CONV_CYCLES cycles), two concurrent conversions:
  - Row: double-dabble to 4 BCD digits over ROW_W cycles, then hold.
  - Column: q=(col-1) div 26, r=(col-1) mod 26, by repeated subtraction of 26, one step per cycle.
- Column byte rules:
  - col=0 -> '@'.
  - col 1..26 -> one byte, 'A'+col-1.
  - col 27..702 -> two bytes, 'A'+q-1 then 'A'+r.
- Row byte rules:
  - Decimal, most significant first, leading zeros suppressed.
  - row=0 -> single '0'.
- Tile byte: '+' (0x2B), '/' (0x2F), '\' (0x5C). Then LF (0x0A).
- Output states: COL1 -> COL2 (skipped if one letter) -> ROWD (1..4 digits) -> TILE -> EOL -> DONE.
- First byte_valid is asserted in the cycle after CONV ends.
- Handshake:
  - A byte transfers on a cycle with byte_valid & byte_ready.
  - byte_valid and byte_data are registered and held stable until transfer.
  - The next byte is presented the cycle after transfer; back-to-back transfers at one byte per 2 cycles minimum.
  - byte_ready while byte_valid=0 is ignored.
- DONE: byte_valid=0, done pulses 1 cycle, busy=0, return to IDLE. New start accepted the cycle after done.

Optional Feature:
- Macro: MOVE_TX_CRLF_EN.
- Defined: CR (0x0D) is emitted in a CR state between TILE and EOL; done follows LF acceptance.
- Undefined: only LF terminates the string, and the CR state is not synthesized.

Decomposition:
- Package trax_move_pkg:
  - Tile code constants (TILE_PLUS, TILE_SLASH, TILE_BSLASH).
  - ASCII constants (CH_AT, CH_A, CH_0, CH_PLUS, CH_SLASH, CH_BSLASH, CH_LF, CH_CR).
  - Move field bit positions and COL_MAX=702.
  - State enum.
- Sub-module bin2bcd_seq: sequential double-dabble.
  - Inputs: load, bin[ROW_W-1:0].
  - Outputs: 4 BCD digits and a ready flag.
  - Instantiated once.

Test Plan:
- Reference move: col=27, row=128, tile=00, byte_ready tied 1 -> bytes 'A','A','1','2','8','+',0x0A; done pulses once; error never asserts.
- Minimum move: col=1, row=1, tile=01 -> "A1/\n". Then col=0, row=0, tile=10 -> "@0\\\n" (bytes 0x40, 0x30, 0x5C, 0x0A).
- Upper bounds: col=702, row=1023, tile=00 -> "ZZ1023+\n"; col=26 -> single 'Z'.
- Rejection: col=703, or tile=11 -> error pulse 2 cycles after start; byte_valid stays 0; busy drops.
- Backpressure: byte_ready low for a random 0..20 cycles per byte -> byte_data stable while valid; byte order and count unchanged. A start issued mid-string is ignored.
- Reset: assert reset after the 3rd byte transfers -> byte_valid=0 the next cycle, all outputs at reset values. A following move is sent complete and correct. With MOVE_TX_CRLF_EN defined, 0x0D precedes 0x0A.

Source files
------------

// File: rtl/trax_move_pkg.sv
// Shared constants, move-word layout and FSM state type for the TRAX move
// ASCII transmitter.
package trax_move_pkg;

  localparam logic [1:0] TILE_PLUS   = 2'b00;
  localparam logic [1:0] TILE_SLASH  = 2'b01;
  localparam logic [1:0] TILE_BSLASH = 2'b10;

  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_A      = 8'h41;
  localparam logic [7:0] CH_0      = 8'h30;
  localparam logic [7:0] CH_PLUS   = 8'h2B;
  localparam logic [7:0] CH_SLASH  = 8'h2F;
  localparam logic [7:0] CH_BSLASH = 8'h5C;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_CR     = 8'h0D;

  localparam int MV_ROW_LSB  = 0;
  localparam int MV_COL_LSB  = 10;
  localparam int MV_TILE_LSB = 20;
  localparam int MV_W        = 22;
  localparam int COL_MAX     = 702;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CHECK, ST_CONV, ST_COL1, ST_COL2,
    ST_ROWD, ST_TILE, ST_CR, ST_EOL, ST_DONE
  } state_e;

  function automatic logic [7:0] tile_char(input logic [1:0] tile);
    case (tile)
      TILE_SLASH:  return CH_SLASH;
      TILE_BSLASH: return CH_BSLASH;
      default:     return CH_PLUS;
    endcase
  endfunction

endpackage

// File: rtl/move_ascii_tx_bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle after load, producing four
// BCD digits (thousands first) and a ready flag once all bits are consumed.
module bin2bcd_seq #(
  parameter int ROW_W = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [ROW_W-1:0] bin,
  output logic [3:0][3:0]  digits,
  output logic             ready
);

  localparam int SR_W  = 16 + ROW_W;
  localparam int CNT_W = $clog2(ROW_W + 1);

  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      if (t[ROW_W+4*i +: 4] >= 4'd5)
        t[ROW_W+4*i +: 4] = t[ROW_W+4*i +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = {16'd0, bin};
      cnt_d = CNT_W'(ROW_W);
    end else if (cnt_q != '0) begin
      sr_d  = dabble(sr_q);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign digits = sr_q[SR_W-1 -: 16];
  assign ready  = (cnt_q == '0);

endmodule

// File: rtl/move_ascii_tx.sv
// Streams a binary TRAX move as "<col letters><row digits><tile>\n" over a
// valid/ready byte port. Define MOVE_TX_CRLF_EN to emit CR before the LF.
module move_ascii_tx
  import trax_move_pkg::*;
#(
  parameter int COL_W       = 10,
  parameter int ROW_W       = 10,
  parameter int CONV_CYCLES = 27
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [MV_W-1:0] move,
  output logic [7:0]      byte_data,
  output logic            byte_valid,
  input  logic            byte_ready,
  output logic            busy,
  output logic            done,
  output logic            error
);

  localparam int CW = $clog2(CONV_CYCLES + 1);

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d, rem_q, rem_d;
  logic [4:0]       quo_q, quo_d;
  logic [1:0]       tile_q, tile_d, dig_q, dig_d, ndig_m1;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       data_q, data_d, col1_byte, cur_byte;
  logic             valid_q, valid_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic             bcd_load, bcd_ready, two_letters;
  logic [3:0][3:0]  digits;
  logic [COL_W-1:0] col_in;

  assign col_in = move[MV_COL_LSB +: COL_W];

  bin2bcd_seq #(.ROW_W(ROW_W)) u_bcd (
    .clock  (clock),
    .reset  (reset),
    .load   (bcd_load),
    .bin    (move[MV_ROW_LSB +: ROW_W]),
    .digits (digits),
    .ready  (bcd_ready)
  );

  // Leading-zero suppression: index of the most significant digit to send.
  always_comb begin
    if (digits[3] != 4'd0)      ndig_m1 = 2'd3;
    else if (digits[2] != 4'd0) ndig_m1 = 2'd2;
    else if (digits[1] != 4'd0) ndig_m1 = 2'd1;
    else                        ndig_m1 = 2'd0;
  end

  assign two_letters = (col_q > COL_W'(26));

  always_comb begin
    if (col_q == '0)      col1_byte = CH_AT;
    else if (two_letters) col1_byte = CH_A + {3'd0, quo_q} - 8'd1;
    else                  col1_byte = CH_A + 8'(col_q) - 8'd1;
  end

  always_comb begin
    case (state_q)
      ST_COL1: cur_byte = col1_byte;
      ST_COL2: cur_byte = CH_A + 8'(rem_q);
      ST_ROWD: cur_byte = CH_0 + {4'd0, digits[dig_q]};
      ST_TILE: cur_byte = tile_char(tile_q);
      ST_CR:   cur_byte = CH_CR;
      default: cur_byte = CH_LF;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    tile_d   = tile_q;
    cnt_d    = cnt_q;
    dig_d    = dig_q;
    data_d   = data_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    bcd_load = 1'b0;

    // (col-1) div/mod 26 by repeated subtraction, runs through CHECK and CONV.
    if ((state_q == ST_CHECK || state_q == ST_CONV) && rem_q >= COL_W'(26)) begin
      rem_d = rem_q - COL_W'(26);
      quo_d = quo_q + 5'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_CHECK;
          busy_d   = 1'b1;
          bcd_load = 1'b1;
          col_d    = col_in;
          rem_d    = (col_in == '0) ? '0 : col_in - COL_W'(1);
          quo_d    = '0;
          tile_d   = move[MV_TILE_LSB +: 2];
        end
      end
      ST_CHECK: begin
        if (tile_q == 2'b11 || col_q > COL_W'(COL_MAX)) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CONV;
          cnt_d   = '0;
        end
      end
      ST_CONV: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(CONV_CYCLES - 1) && bcd_ready) begin
          state_d = ST_COL1;
          valid_d = 1'b1;
          data_d  = col1_byte;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        // Byte states: present one byte, then advance on its transfer.
        if (!valid_q) begin
          valid_d = 1'b1;
          data_d  = cur_byte;
        end else if (byte_ready) begin
          valid_d = 1'b0;
          case (state_q)
            ST_COL1: begin
              state_d = two_letters ? ST_COL2 : ST_ROWD;
              dig_d   = ndig_m1;
            end
            ST_COL2: begin
              state_d = ST_ROWD;
              dig_d   = ndig_m1;
            end
            ST_ROWD: begin
              if (dig_q == 2'd0) state_d = ST_TILE;
              else               dig_d   = dig_q - 2'd1;
            end
`ifdef MOVE_TX_CRLF_EN
            ST_TILE: state_d = ST_CR;
            ST_CR:   state_d = ST_EOL;
`else
            ST_TILE: state_d = ST_EOL;
`endif
            default: begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      tile_q  <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      tile_q  <= tile_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign byte_data  = data_q;
  assign byte_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_move_ascii_tx.sv
// Directed bench for move_ascii_tx: expected strings are built from the
// move fields with plain integer arithmetic and compared byte by byte.
module tb_move_ascii_tx;
  import trax_move_pkg::*;

  localparam int CONV_CYCLES = 27;

  logic        clock = 1'b0;
  logic        reset, start, byte_ready;
  logic [21:0] move;
  logic [7:0]  byte_data;
  logic        byte_valid, busy, done, error;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clock = ~clock;

  move_ascii_tx #(.COL_W(10), .ROW_W(10), .CONV_CYCLES(CONV_CYCLES)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .move       (move),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic build_exp(input int col, input int row, input logic [1:0] tile);
    string s;
    exp_q.delete();
    if (col == 0)       exp_q.push_back(8'h40);
    else if (col <= 26) exp_q.push_back(8'(8'h41 + col - 1));
    else begin
      exp_q.push_back(8'(8'h41 + (col - 1) / 26 - 1));
      exp_q.push_back(8'(8'h41 + (col - 1) % 26));
    end
    s = $sformatf("%0d", row);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    case (tile)
      2'b00:   exp_q.push_back(8'h2B);
      2'b01:   exp_q.push_back(8'h2F);
      default: exp_q.push_back(8'h5C);
    endcase
`ifdef MOVE_TX_CRLF_EN
    exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(8'h0A);
  endtask

  task automatic drive_start(input int col, input int row, input logic [1:0] tile);
    move = '0;
    move[MV_TILE_LSB +: 2] = tile;
    move[MV_COL_LSB +: 10] = 10'(col);
    move[MV_ROW_LSB +: 10] = 10'(row);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send(input string tag, input int col, input int row, input logic [1:0] tile,
                      input int bp, input bit poke);
    int n, first_v, done_cnt, err_cnt, wait_cnt;
    bit stable_ok, pending, finished, stray;
    logic [7:0] held;
    build_exp(col, row, tile);
    got_q.delete();
    n = 0; first_v = -1; done_cnt = 0; err_cnt = 0;
    wait_cnt = (bp > 0) ? $urandom_range(bp, 0) : 0;
    stable_ok = 1'b1; pending = 1'b0; finished = 1'b0; held = '0;
    drive_start(col, row, tile);
    while (!finished && n < 4000) begin
      n++;
      if (pending && (!byte_valid || byte_data !== held)) stable_ok = 1'b0;
      if (byte_valid && first_v < 0) first_v = n;
      if (done) begin done_cnt++; finished = 1'b1; end
      if (error) err_cnt++;
      if (poke) begin
        start = (n == 40);
        if (n == 40) move = 22'h0_0C05;
      end
      if (byte_valid) begin
        if (wait_cnt > 0) begin
          byte_ready = 1'b0; wait_cnt--; pending = 1'b1; held = byte_data;
        end else begin
          byte_ready = 1'b1; got_q.push_back(byte_data); pending = 1'b0;
          wait_cnt = (bp > 0) ? $urandom_range(bp, 0) : 0;
        end
      end else begin
        byte_ready = 1'($urandom_range(1, 0));
        pending = 1'b0;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    byte_ready = 1'b0;
    check({tag, " finished"}, 32'(finished), 32'd1);
    check({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s byte%0d", tag, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF,
            32'(exp_q[i]));
    check({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, " error"}, 32'(err_cnt), 32'd0);
    check({tag, " first_valid"}, 32'(first_v), 32'(CONV_CYCLES + 2));
    check({tag, " stable"}, 32'(stable_ok), 32'd1);
    check({tag, " done_after"}, 32'(done), 32'd0);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    if (poke) begin
      stray = 1'b0;
      for (int i = 0; i < 60; i++) begin
        if (byte_valid || busy) stray = 1'b1;
        @(posedge clock); #1;
      end
      check({tag, " ignored_start"}, 32'(stray), 32'd0);
    end
  endtask

  task automatic reject(input string tag, input int col, input int row, input logic [1:0] tile);
    drive_start(col, row, tile);
    check({tag, " chk_busy"}, 32'(busy), 32'd1);
    check({tag, " chk_err"}, 32'(error), 32'd0);
    @(posedge clock); #1;
    check({tag, " err"}, 32'(error), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " valid"}, 32'(byte_valid), 32'd0);
    @(posedge clock); #1;
    check({tag, " err_end"}, 32'(error), 32'd0);
    check({tag, " valid_end"}, 32'(byte_valid), 32'd0);
  endtask

  task automatic reset_mid_string();
    int xfers, n;
    bit stray;
    xfers = 0; n = 0;
    drive_start(27, 128, 2'b00);
    byte_ready = 1'b1;
    while (xfers < 3 && n < 400) begin
      n++;
      if (byte_valid) xfers++;
      @(posedge clock); #1;
    end
    check("rst xfers", 32'(xfers), 32'd3);
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst valid", 32'(byte_valid), 32'd0);
    check("rst data", 32'(byte_data), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst error", 32'(error), 32'd0);
    reset = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (byte_valid || busy || done) stray = 1'b1;
      @(posedge clock); #1;
    end
    byte_ready = 1'b0;
    check("rst quiet", 32'(stray), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; byte_ready = 1'b0; move = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset valid", 32'(byte_valid), 32'd0);
    check("reset data", 32'(byte_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset error", 32'(error), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    send("ref", 27, 128, 2'b00, 0, 1'b0);
    send("min", 1, 1, 2'b01, 0, 1'b0);
    send("zero", 0, 0, 2'b10, 0, 1'b0);
    send("upper", 702, 1023, 2'b00, 0, 1'b0);
    send("col26", 26, 5, 2'b01, 0, 1'b0);
    reject("rej_col", 703, 5, 2'b00);
    reject("rej_tile", 5, 5, 2'b11);
    send("bp1", 100, 907, 2'b10, 20, 1'b1);
    send("bp2", 53, 40, 2'b00, 20, 1'b0);
    reset_mid_string();
    send("post_rst", 27, 128, 2'b00, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
